// File: rtl/gfx_vram_writer_if.sv
// gfx_vram_writer_if
// Groups the signals of the VRAM write queue:
//   - the CPU request side: i_req_valid, o_req_ready, i_req_addr, i_req_data
//     and, when GFX_VRAM_WRITER_AUTOINC_EN is defined, i_req_autoinc;
//   - the VGA arbitration input i_free_vbus_b;
//   - the VRAM pin side: o_vaddr, o_vdata, o_vdata_oe, o_vwe_b, o_vbus_own;
//   - status: o_busy, o_fifo_level.
// slave  : the writer block (drives the o_* signals).
// master : the surroundings (CPU decoder, VGA generator, pins).
// FIFO_DEPTH must match the writer so that o_fifo_level has the same width.
interface gfx_vram_writer_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic          i_req_valid;
    logic          o_req_ready;
    logic [15:0]   i_req_addr;
    logic [7:0]    i_req_data;
`ifdef GFX_VRAM_WRITER_AUTOINC_EN
    logic          i_req_autoinc;
`endif
    logic          i_free_vbus_b;
    logic [15:0]   o_vaddr;
    logic [7:0]    o_vdata;
    logic          o_vdata_oe;
    logic          o_vwe_b;
    logic          o_vbus_own;
    logic          o_busy;
    logic [LW-1:0] o_fifo_level;

    modport slave (
        input  i_req_valid,
        input  i_req_addr,
        input  i_req_data,
`ifdef GFX_VRAM_WRITER_AUTOINC_EN
        input  i_req_autoinc,
`endif
        input  i_free_vbus_b,
        output o_req_ready,
        output o_vaddr,
        output o_vdata,
        output o_vdata_oe,
        output o_vwe_b,
        output o_vbus_own,
        output o_busy,
        output o_fifo_level
    );

    modport master (
        output i_req_valid,
        output i_req_addr,
        output i_req_data,
`ifdef GFX_VRAM_WRITER_AUTOINC_EN
        output i_req_autoinc,
`endif
        output i_free_vbus_b,
        input  o_req_ready,
        input  o_vaddr,
        input  o_vdata,
        input  o_vdata_oe,
        input  o_vwe_b,
        input  o_vbus_own,
        input  o_busy,
        input  o_fifo_level
    );
endinterface

// File: rtl/gfx_vram_writer.sv
// gfx_vram_writer
// Queues CPU write requests (address + byte) in a small FIFO and replays them
// onto the shared VRAM bus, only starting a write while the VGA generator
// reports the bus free (i_free_vbus_b low). Each write is SETUP (1 cycle),
// STROBE (WE_CYCLES cycles, o_vwe_b low), HOLD (1 cycle); from HOLD the next
// queued write may start immediately without passing through IDLE.
// Ports:
//   i_clk  - system clock (shared with the VGA generator)
//   i_rst  - asynchronous, active-high reset
//   bus    - gfx_vram_writer_if.slave: request handshake, bus-free input,
//            VRAM address/data/strobe outputs, busy and FIFO level
// Optional feature: define GFX_VRAM_WRITER_AUTOINC_EN to add i_req_autoinc;
// an autoinc push targets last pushed address + 1 (first one lands at 0).
module gfx_vram_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int WE_CYCLES  = 1
) (
    input logic                  i_clk,
    input logic                  i_rst,
    gfx_vram_writer_if.slave     bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    logic [23:0]   mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic [LW-1:0] level_nxt_s;
    logic          push_s;
    logic          pop_s;
    logic          fifo_empty_s;
    logic [15:0]   push_addr_s;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [1:0]    strb_cnt_r;
    logic          strb_last_s;

    logic          vwe_b_s;
    logic          oe_s;
    logic          own_s;

    logic          ready_r;
    logic          vwe_b_r;
    logic          oe_r;
    logic          own_r;
    logic          busy_r;
    logic [15:0]   vaddr_r;
    logic [7:0]    vdata_r;

    assign fifo_empty_s = (level_r == {LW{1'b0}});
    assign push_s       = bus.i_req_valid & ready_r;
    assign strb_last_s  = (strb_cnt_r == 2'(WE_CYCLES - 1));

`ifdef GFX_VRAM_WRITER_AUTOINC_EN
    logic [15:0] last_addr_r;

    // Autoinc pushes continue from the previously pushed address (wraps at 16'hFFFF).
    always_comb begin
        push_addr_s = bus.i_req_addr;
        if (bus.i_req_autoinc) begin
            push_addr_s = last_addr_r + 16'd1;
        end else begin
            push_addr_s = bus.i_req_addr;
        end
    end

    // Last pushed address; resets to 16'hFFFF so the first autoinc push hits 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_addr_r <= 16'hFFFF;
        end else if (push_s) begin
            last_addr_r <= push_addr_s;
        end
    end
`else
    assign push_addr_s = bus.i_req_addr;
`endif

    // FIFO storage; contents need no reset because level/pointers gate every read.
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {push_addr_s, bus.i_req_data};
        end
    end

    // Occupancy after this edge; push and pop together leave it unchanged.
    always_comb begin
        level_nxt_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + {{(LW-1){1'b0}}, 1'b1};
            2'b01:   level_nxt_s = level_r - {{(LW-1){1'b0}}, 1'b1};
            default: level_nxt_s = level_r;
        endcase
    end

    // FIFO pointers and level; pointers wrap naturally because depth is a power of two.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
            level_r <= level_nxt_s;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Strobe length counter: runs only inside STROBE, cleared everywhere else.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            strb_cnt_r <= 2'd0;
        end else if ((state_r == ST_STROBE) && !strb_last_s) begin
            strb_cnt_r <= strb_cnt_r + 2'd1;
        end else begin
            strb_cnt_r <= 2'd0;
        end
    end

    // FSM next state; a write is only started (pop) at the IDLE/HOLD decision edge.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s && !bus.i_free_vbus_b) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ST_SETUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_nxt_s = ST_STROBE;
            end
            ST_STROBE: begin
                if (strb_last_s) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_STROBE;
                end
            end
            ST_HOLD: begin
                if (!fifo_empty_s && !bus.i_free_vbus_b) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ST_SETUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Bus control decoded from the next state so the registered pins line up with the state.
    always_comb begin
        vwe_b_s = 1'b1;
        oe_s    = 1'b0;
        own_s   = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                vwe_b_s = 1'b1;
                oe_s    = 1'b0;
                own_s   = 1'b0;
            end
            ST_SETUP, ST_HOLD: begin
                vwe_b_s = 1'b1;
                oe_s    = 1'b1;
                own_s   = 1'b1;
            end
            ST_STROBE: begin
                vwe_b_s = 1'b0;
                oe_s    = 1'b1;
                own_s   = 1'b1;
            end
            default: begin
                vwe_b_s = 1'b1;
                oe_s    = 1'b0;
                own_s   = 1'b0;
            end
        endcase
    end

    // Registered outputs; address/data load on pop and otherwise hold their last value.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ready_r <= 1'b1;
            vwe_b_r <= 1'b1;
            oe_r    <= 1'b0;
            own_r   <= 1'b0;
            busy_r  <= 1'b0;
            vaddr_r <= 16'h0000;
            vdata_r <= 8'h00;
        end else begin
            ready_r <= (level_nxt_s < LW'(FIFO_DEPTH));
            vwe_b_r <= vwe_b_s;
            oe_r    <= oe_s;
            own_r   <= own_s;
            busy_r  <= (level_nxt_s != {LW{1'b0}}) || (state_nxt_s != ST_IDLE);
            if (pop_s) begin
                vaddr_r <= mem_r[rd_ptr_r][23:8];
                vdata_r <= mem_r[rd_ptr_r][7:0];
            end
        end
    end

    assign bus.o_req_ready  = ready_r;
    assign bus.o_vaddr      = vaddr_r;
    assign bus.o_vdata      = vdata_r;
    assign bus.o_vdata_oe   = oe_r;
    assign bus.o_vwe_b      = vwe_b_r;
    assign bus.o_vbus_own   = own_r;
    assign bus.o_busy       = busy_r;
    assign bus.o_fifo_level = level_r;
endmodule
